// File: rtl/acc_readout_framer_if.sv
// Byte-wide valid/ready link from the readout framer to the transmit path.
// Data is accepted on any clock edge where valid and ready are both high.
interface acc_readout_framer_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (
        output data,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        output ready
    );
endinterface

// File: rtl/acc_readout_framer.sv
// Reads RECORD_BYTES from accumulator storage, emits header/payload/checksum frame.
// Optional ACC_FRAME_SEQ_EN inserts a big-endian 16-bit sequence number after the header.
module acc_readout_framer #(
    parameter int          RECORD_BYTES = 1024,
    parameter int          READ_LATENCY = 2,
    parameter logic [7:0]  HDR_BYTE     = 8'hA5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 data_ready_i,
    input  logic [7:0]           data_in_i,
    output logic                 read_enable_o,
    output logic                 busy_o,
    output logic                 frame_done_o,
    output logic                 frame_abort_o,
    acc_readout_framer_if.master tx
);

    localparam logic [15:0] REC      = 16'(RECORD_BYTES);
    localparam logic [2:0]  LAT_INIT = 3'(READ_LATENCY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
`ifdef ACC_FRAME_SEQ_EN
        S_SEQ_HI,
        S_SEQ_LO,
`endif
        S_LAT,
        S_SEND,
        S_NEXT,
        S_CSUM
    } state_t;

    state_t      state_q;
    logic [7:0]  tx_data_q;
    logic        tx_valid_q;
    logic        busy_q;
    logic        re_q;
    logic        done_q;
    logic        abort_q;
    logic [15:0] cnt_q;
    logic [7:0]  csum_q;
    logic [2:0]  lat_q;
`ifdef ACC_FRAME_SEQ_EN
    logic [15:0] seq_q;
`endif

    logic        accept;
    logic        abort_now;
    logic [15:0] cnt_d;
    logic [7:0]  csum_d;
    logic [2:0]  lat_d;

    always_comb begin
        accept    = tx_valid_q & tx.ready;
        cnt_d     = cnt_q + 16'd1;
        csum_d    = csum_q + tx_data_q;
        lat_d     = (lat_q != 3'd0) ? lat_q - 3'd1 : 3'd0;
        abort_now = 1'b0;
        if (!data_ready_i) begin
            abort_now = (state_q == S_LAT)
                     || (state_q == S_SEND)
                     || (state_q == S_NEXT);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            re_q       <= 1'b0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
            cnt_q      <= 16'd0;
            csum_q     <= 8'h00;
            lat_q      <= 3'd0;
`ifdef ACC_FRAME_SEQ_EN
            seq_q      <= 16'd0;
`endif
        end else begin
            re_q    <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            // a same-cycle accept in SEND is discarded by the clear anyway
            if (abort_now) begin
                abort_q    <= 1'b1;
                tx_valid_q <= 1'b0;
                busy_q     <= 1'b0;
                cnt_q      <= 16'd0;
                csum_q     <= 8'h00;
                lat_q      <= 3'd0;
                state_q    <= S_IDLE;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (data_ready_i) begin
                            lat_q      <= LAT_INIT;
                            busy_q     <= 1'b1;
                            tx_data_q  <= HDR_BYTE;
                            tx_valid_q <= 1'b1;
                            state_q    <= S_HDR;
                        end
                    end
                    S_HDR: begin
                        lat_q <= lat_d;
                        if (accept) begin
`ifdef ACC_FRAME_SEQ_EN
                            tx_data_q  <= seq_q[15:8];
                            state_q    <= S_SEQ_HI;
`else
                            tx_valid_q <= 1'b0;
                            state_q    <= S_LAT;
`endif
                        end
                    end
`ifdef ACC_FRAME_SEQ_EN
                    S_SEQ_HI: begin
                        lat_q <= lat_d;
                        if (accept) begin
                            tx_data_q <= seq_q[7:0];
                            state_q   <= S_SEQ_LO;
                        end
                    end
                    S_SEQ_LO: begin
                        lat_q <= lat_d;
                        if (accept) begin
                            tx_valid_q <= 1'b0;
                            state_q    <= S_LAT;
                        end
                    end
`endif
                    S_LAT: begin
                        if (lat_q == 3'd0) begin
                            tx_data_q  <= data_in_i;
                            tx_valid_q <= 1'b1;
                            state_q    <= S_SEND;
                        end else begin
                            lat_q <= lat_d;
                        end
                    end
                    S_SEND: begin
                        if (accept) begin
                            csum_q <= csum_d;
                            cnt_q  <= cnt_d;
                            if (cnt_d == REC) begin
                                tx_data_q <= csum_d;
                                state_q   <= S_CSUM;
                            end else begin
                                tx_valid_q <= 1'b0;
                                re_q       <= 1'b1;
                                state_q    <= S_NEXT;
                            end
                        end
                    end
                    S_NEXT: begin
                        lat_q   <= LAT_INIT;
                        state_q <= S_LAT;
                    end
                    S_CSUM: begin
                        if (accept) begin
                            tx_valid_q <= 1'b0;
                            done_q     <= 1'b1;
                            busy_q     <= 1'b0;
                            cnt_q      <= 16'd0;
                            csum_q     <= 8'h00;
`ifdef ACC_FRAME_SEQ_EN
                            seq_q      <= seq_q + 16'd1;
`endif
                            state_q    <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign tx.data       = tx_data_q;
    assign tx.valid      = tx_valid_q;
    assign busy_o        = busy_q;
    assign read_enable_o = re_q;
    assign frame_done_o  = done_q;
    assign frame_abort_o = abort_q;

endmodule

// File: tb/tb_acc_readout_framer.sv
// Self-checking bench for acc_readout_framer with a small storage model.
// Expected frames are built from the payload array with plain arithmetic.
module tb_acc_readout_framer;

    localparam int RB = 4;
    localparam int L  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       data_ready = 1'b0;
    logic [7:0] data_in;
    logic       re;
    logic       busy;
    logic       done;
    logic       abort;

    acc_readout_framer_if tx();

    acc_readout_framer #(
        .RECORD_BYTES (RB),
        .READ_LATENCY (L),
        .HDR_BYTE     (8'hA5)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .data_ready_i  (data_ready),
        .data_in_i     (data_in),
        .read_enable_o (re),
        .busy_o        (busy),
        .frame_done_o  (done),
        .frame_abort_o (abort),
        .tx            (tx)
    );

    always #5 clk = ~clk;

    // storage: a ReadEnable pulse shows the next byte two cycles later
    logic [7:0] pay [RB];
    int         idx = 0;
    logic       re_d1 = 1'b0;
    logic       st_clr = 1'b0;

    always @(posedge clk) begin
        if (st_clr) begin
            idx   <= 0;
            re_d1 <= 1'b0;
        end else begin
            re_d1 <= re;
            if (re_d1) idx <= idx + 1;
        end
    end

    assign data_in = (idx < RB) ? pay[idx] : 8'h00;

    byte unsigned rx[$];
    byte unsigned exp_q[$];
    int re_cnt = 0, done_cnt = 0, abort_cnt = 0;
    int viol_cnt = 0, stab_cnt = 0;
    bit prev_stall = 0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (tx.valid && tx.ready) rx.push_back(tx.data);
            if (re) re_cnt++;
            if (done) done_cnt++;
            if (abort) abort_cnt++;
            if (re && tx.valid && !tx.ready) viol_cnt++;
            if (prev_stall && !abort &&
                (!tx.valid || tx.data != prev_data)) stab_cnt++;
            prev_stall = tx.valid && !tx.ready;
            prev_data  = tx.data;
        end
    end

    int checks = 0;
    int errors = 0;
    int exp_seq = 0;
    int fstart = 0;
    bit post_valid, post_busy;

    task automatic make_exp();
        int s;
        s = 0;
        exp_q.delete();
        exp_q.push_back(8'hA5);
`ifdef ACC_FRAME_SEQ_EN
        exp_q.push_back(8'((exp_seq >> 8) & 255));
        exp_q.push_back(8'(exp_seq & 255));
`endif
        for (int i = 0; i < RB; i++) begin
            exp_q.push_back(pay[i]);
            s = s + int'(pay[i]);
        end
        exp_q.push_back(8'(s % 256));
    endtask

    function automatic int first_diff(input int n);
        if (rx.size() - fstart != n) return -2;
        for (int i = 0; i < n; i++)
            if (rx[fstart + i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic run_frame(input int rmode, input int abort_at,
                             output bit to);
        int stall_left;
        bit stalled;
        int aw;
        stall_left = 0;
        stalled = 0;
        aw = -1;
        to = 1;
        st_clr = 1'b1;
        @(posedge clk); #1;
        st_clr = 1'b0;
        fstart = rx.size();
        data_ready = 1'b1;
        tx.ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (done) begin
                to = 0;
                data_ready = 1'b0;
                exp_seq = (exp_seq + 1) & 16'hFFFF;
                break;
            end
            if (abort) begin
                to = 0;
                break;
            end
            if (abort_at > 0 && aw < 0 && rx.size() - fstart >= abort_at)
                aw = 1;
            else if (aw > 0) begin
                aw = 0;
                data_ready = 1'b0;
            end
            if (rmode == 2 && !stalled && rx.size() - fstart >= 3) begin
                stalled = 1;
                stall_left = 50;
            end
            if (stall_left > 0) begin
                tx.ready = 1'b0;
                stall_left--;
            end else if (rmode == 0) tx.ready = 1'b1;
            else tx.ready = 1'($urandom_range(0, 1));
        end
        post_valid = tx.valid;
        post_busy  = busy;
        data_ready = 1'b0;
        tx.ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tx.ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({re, busy, done, abort, tx.valid, tx.data} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0",
                     {re, busy, done, abort, tx.valid, tx.data});
        end
        rst = 1'b0;
        exp_seq = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        bit to;
        int r0, d0, a0, fd;
        for (int i = 0; i < RB; i++) pay[i] = 8'(i + 1);
        make_exp();
        r0 = re_cnt; d0 = done_cnt; a0 = abort_cnt;
        run_frame(0, 0, to);
        checks++;
        if (to) begin errors++; $display("FAIL basic_timeout got 1 want 0"); end
        fd = first_diff(exp_q.size());
        checks++;
        if (fd != -1) begin
            errors++;
            $display("FAIL basic_frame diff %0d size %0d want %0d",
                     fd, rx.size() - fstart, exp_q.size());
        end
        checks++;
        if (rx[rx.size() - 1] !== 8'h0A) begin
            errors++;
            $display("FAIL basic_csum got %h want 0a", rx[rx.size() - 1]);
        end
        checks++;
        if (re_cnt - r0 != RB - 1) begin
            errors++;
            $display("FAIL basic_re got %0d want %0d", re_cnt - r0, RB - 1);
        end
        checks++;
        if (done_cnt - d0 != 1 || abort_cnt - a0 != 0) begin
            errors++;
            $display("FAIL basic_pulses done %0d abort %0d want 1 0",
                     done_cnt - d0, abort_cnt - a0);
        end
    endtask

    task automatic test_stall();
        bit to;
        int r0, v0, s0, fd;
        for (int i = 0; i < RB; i++) pay[i] = 8'($urandom_range(0, 255));
        make_exp();
        r0 = re_cnt; v0 = viol_cnt; s0 = stab_cnt;
        run_frame(2, 0, to);
        fd = first_diff(exp_q.size());
        checks++;
        if (to || fd != -1) begin
            errors++;
            $display("FAIL stall_frame timeout %0d diff %0d want 0 -1", to, fd);
        end
        checks++;
        if (viol_cnt - v0 != 0) begin
            errors++;
            $display("FAIL stall_re_while_stalled got %0d want 0", viol_cnt - v0);
        end
        checks++;
        if (stab_cnt - s0 != 0) begin
            errors++;
            $display("FAIL stall_stability got %0d want 0", stab_cnt - s0);
        end
        checks++;
        if (re_cnt - r0 != RB - 1) begin
            errors++;
            $display("FAIL stall_re got %0d want %0d", re_cnt - r0, RB - 1);
        end
    endtask

    task automatic test_random();
        bit to;
        int fd;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < RB; i++) pay[i] = 8'($urandom_range(0, 255));
            make_exp();
            run_frame(1, 0, to);
            fd = first_diff(exp_q.size());
            checks++;
            if (to || fd != -1) begin
                errors++;
                $display("FAIL random_frame%0d timeout %0d diff %0d", k, to, fd);
            end
        end
    endtask

    task automatic test_wrap();
        bit to;
        int fd;
        for (int i = 0; i < RB; i++) pay[i] = 8'hFF;
        make_exp();
        run_frame(0, 0, to);
        fd = first_diff(exp_q.size());
        checks++;
        if (to || fd != -1) begin
            errors++;
            $display("FAIL wrap_frame timeout %0d diff %0d", to, fd);
        end
        checks++;
        if (rx[rx.size() - 1] !== 8'hFC) begin
            errors++;
            $display("FAIL wrap_csum got %h want fc", rx[rx.size() - 1]);
        end
    endtask

    task automatic test_abort();
        bit to;
        int a0, d0, fd, hb;
        for (int i = 0; i < RB; i++) pay[i] = 8'($urandom_range(0, 255));
        make_exp();
        hb = exp_q.size() - RB - 1 + 2;
        a0 = abort_cnt; d0 = done_cnt;
        run_frame(0, hb, to);
        checks++;
        if (to || abort_cnt - a0 != 1 || done_cnt - d0 != 0) begin
            errors++;
            $display("FAIL abort_pulse timeout %0d abort %0d done %0d want 0 1 0",
                     to, abort_cnt - a0, done_cnt - d0);
        end
        checks++;
        if (post_valid !== 1'b0 || post_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_outputs valid %0d busy %0d want 0 0",
                     post_valid, post_busy);
        end
        fd = first_diff(hb);
        checks++;
        if (fd != -1) begin
            errors++;
            $display("FAIL abort_partial diff %0d size %0d want %0d",
                     fd, rx.size() - fstart, hb);
        end
        make_exp();
        run_frame(0, 0, to);
        fd = first_diff(exp_q.size());
        checks++;
        if (to || fd != -1) begin
            errors++;
            $display("FAIL abort_restart timeout %0d diff %0d", to, fd);
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        int a0, fd;
        for (int i = 0; i < RB; i++) pay[i] = 8'($urandom_range(0, 255));
        make_exp();
        st_clr = 1'b1;
        @(posedge clk); #1;
        st_clr = 1'b0;
        fstart = rx.size();
        data_ready = 1'b1;
        tx.ready = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (rx.size() - fstart >= exp_q.size() - RB + 1) break;
        end
        tx.ready = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (tx.valid !== 1'b1 || tx.data !== exp_q[exp_q.size() - RB + 1]) begin
            errors++;
            $display("FAIL midreset_held valid %0d data %h want 1 %h",
                     tx.valid, tx.data, exp_q[exp_q.size() - RB + 1]);
        end
        a0 = abort_cnt;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({re, busy, done, abort, tx.valid, tx.data} !== 13'd0) begin
            errors++;
            $display("FAIL midreset_outputs got %h want 0",
                     {re, busy, done, abort, tx.valid, tx.data});
        end
        rst = 1'b0;
        data_ready = 1'b0;
        tx.ready = 1'b1;
        exp_seq = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (abort_cnt != a0) begin
            errors++;
            $display("FAIL midreset_abort got %0d want 0", abort_cnt - a0);
        end
        make_exp();
        run_frame(1, 0, to);
        fd = first_diff(exp_q.size());
        checks++;
        if (to || fd != -1) begin
            errors++;
            $display("FAIL midreset_after timeout %0d diff %0d", to, fd);
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        int fd, hb;
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < RB; i++) pay[i] = 8'($urandom_range(0, 255));
            make_exp();
            hb = exp_q.size() - RB - 1 + 1;
            run_frame(1, (f == 1) ? hb : 0, to);
            fd = first_diff((f == 1) ? hb : exp_q.size());
            checks++;
            if (to || fd != -1) begin
                errors++;
                $display("FAIL b2b_frame%0d timeout %0d diff %0d", f, to, fd);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        tx.ready = 1'b0;
        for (int i = 0; i < RB; i++) pay[i] = 8'h00;
        test_reset();
        test_basic();
        test_stall();
        test_random();
        test_wrap();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
